blind_motor_scheduler: RTL and testbench
========================================

Name: blind_motor_scheduler

Overview:
- Arbitrates open/close requests from manual buttons and the automatic light/timer logic onto the single blind motor.
- Sequences the motor with a direction-reversal dead time, limit-switch stops and a travel-timeout fault.
- Sits between the input decode of the blind FSM top (tt_um_fsm_Yankel2025) and the uo_out motor pins.

Parameters:
- DEAD_CYCLES, 16: idle cycles with both motor outputs low, inserted after every motion stop.
- TRAVEL_MAX, 1000: maximum cycles in UP/DOWN before a missing limit switch is declared a FAULT.
- CNT_W, 12: counter width; must hold max(DEAD_CYCLES, TRAVEL_MAX).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_man_up  in  1  manual open request, level
- req_man_dn  in  1  manual close request, level
- req_auto_up  in  1  automatic open request, level
- req_auto_dn  in  1  automatic close request, level
- stop  in  1  stop command, level, highest priority
- clear_fault  in  1  one-cycle pulse; leaves FAULT
- lim_top  in  1  fully-open limit switch, already synchronised
- lim_bot  in  1  fully-closed limit switch, already synchronised
- motor_up  out  1  drive motor to open (registered)
- motor_dn  out  1  drive motor to close (registered)
- grant_src  out  2  source owning current motion: 00 none, 01 manual, 10 auto
- state_o  out  3  FSM state code: IDLE=0, UP=1, DOWN=2, DEAD=3, FAULT=4
- fault  out  1  high while in FAULT

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous, active-high. On rst, all outputs are 0, state is IDLE, and the counter and pending register are cleared.
- Request decode:
  - A source asserting up and down in the same cycle counts as no request from that source.
  - Priority: stop > manual > auto.
- IDLE:
  - stop high: stay in IDLE.
  - Otherwise the winning up request with lim_top=0 goes to UP; the winning down request with lim_bot=0 goes to DOWN.
  - A request toward an already-asserted limit is ignored.
  - grant_src latches the winning source.
- Latency: a request sampled at edge N gives motor_up or motor_dn = 1 after edge N.
- UP (motor_up=1) / DOWN (motor_dn=1):
  - The travel counter increments every cycle.
  - Own limit asserted, or stop: go to DEAD with pending = none.
  - Manual request in the opposite direction: go to DEAD with pending = opposite direction, pending source = manual.
  - Manual request in the same direction: ignored.
  - Auto requests: ignored during motion, including when the motion was granted to auto.
  - Counter reaches TRAVEL_MAX-1 with no limit: go to FAULT.
- DEAD:
  - Both motor outputs low and grant_src = 00. The counter runs from 0 to DEAD_CYCLES-1.
  - On expiry: go to the pending direction if its limit is clear and stop is low; otherwise go to IDLE. Pending is then cleared.
  - stop during DEAD clears pending.
- FAULT:
  - Motor outputs 0, fault=1, all requests ignored.
  - A clear_fault pulse moves to DEAD with pending = none, so a dead time always precedes the next motion.
- lim_top and lim_bot both high in any state except FAULT: go to FAULT on the next edge, overriding all other transitions.
- Invariants:
  - motor_up and motor_dn are never both 1.
  - A direction reversal always has at least DEAD_CYCLES cycles with both outputs low.
- Counter: cleared on every state entry; no wrap-around, it saturates at its terminal value.
- Reset mid-motion: motor outputs drop asynchronously, with no dead time applied.

Optional Feature:
- Macro: AUTO_LOCKOUT_EN.
- Defined:
  - A LOCKOUT_CYCLES parameter (default 4096) is added, with a lockout counter of width CNT_W+2 bits.
  - Each manual grant reloads the counter. While it is nonzero, auto requests are ignored in IDLE as well.
  - The counter decrements each cycle and saturates at 0. rst clears it.
- Undefined: no lockout parameter, counter or logic; auto requests are accepted in IDLE immediately.

Test Plan:
- Bench settings for all scenarios: DEAD_CYCLES=4, TRAVEL_MAX=20.
- Manual up: req_man_up=1 at edge 0 → motor_up=1 and grant_src=01 from edge 1; lim_top=1 at edge 8 → motor_up=0 from edge 9; state DEAD for 4 cycles, then IDLE.
- Reversal: DOWN granted to auto, then req_man_up=1 → motor_dn falls, both outputs 0 for exactly 4 cycles, then motor_up=1 with grant_src=01.
- Priority: req_man_dn=1 and req_auto_up=1 in the same cycle in IDLE → DOWN, grant_src=01. With stop=1 also high → stays IDLE.
- Timeout: req_auto_up=1 with no limit → FAULT after 20 cycles of UP, fault=1, motors 0; requests ignored until clear_fault → DEAD (4 cycles) → IDLE.
- Sensor error: lim_top=lim_bot=1 during UP → FAULT on the next edge.
- Async reset: rst=1 mid-DOWN → motor_dn=0 and state_o=0 with no clock edge.
- AUTO_LOCKOUT_EN, LOCKOUT_CYCLES=10: manual move completes, then req_auto_dn=1 → ignored until 10 cycles after the grant, then DOWN.

Source files
------------

// File: rtl/blind_motor_scheduler.sv
// Blind motor scheduler: arbitrates manual/auto open-close requests onto one motor with dead time,
// limit stops and travel timeout. Optional macro AUTO_LOCKOUT_EN blocks auto requests after manual use.
module blind_motor_scheduler #(
  parameter int unsigned DEAD_CYCLES    = 16,
  parameter int unsigned TRAVEL_MAX     = 1000,
  parameter int unsigned CNT_W          = 12
`ifdef AUTO_LOCKOUT_EN
  ,
  parameter int unsigned LOCKOUT_CYCLES = 4096
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_man_up,
  input  logic       req_man_dn,
  input  logic       req_auto_up,
  input  logic       req_auto_dn,
  input  logic       stop,
  input  logic       clear_fault,
  input  logic       lim_top,
  input  logic       lim_bot,
  output logic       motor_up,
  output logic       motor_dn,
  output logic [1:0] grant_src,
  output logic [2:0] state_o,
  output logic       fault
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StUp    = 3'd1,
    StDown  = 3'd2,
    StDead  = 3'd3,
    StFault = 3'd4
  } state_e;

  typedef enum logic [1:0] {PendNone, PendUp, PendDn} pend_e;

  localparam logic [CNT_W-1:0] TravelLast = CNT_W'(TRAVEL_MAX - 1);
  localparam logic [CNT_W-1:0] DeadLast   = CNT_W'(DEAD_CYCLES - 1);

  state_e           state_q, state_d;
  pend_e            pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       grant_q, grant_d;
  logic             motor_up_q, motor_dn_q, fault_q;
  logic             manual_grant;
  logic             auto_en;

  // A source asserting both directions at once counts as no request.
  logic man_up, man_dn, man_any, auto_up, auto_dn, win_up, win_dn;
  assign man_up  = req_man_up & ~req_man_dn;
  assign man_dn  = req_man_dn & ~req_man_up;
  assign man_any = man_up | man_dn;
  assign auto_up = req_auto_up & ~req_auto_dn;
  assign auto_dn = req_auto_dn & ~req_auto_up;
  assign win_up  = man_up | (~man_any & auto_en & auto_up);
  assign win_dn  = man_dn | (~man_any & auto_en & auto_dn);

`ifdef AUTO_LOCKOUT_EN
  localparam logic [CNT_W+1:0] LockLoad = (CNT_W + 2)'(LOCKOUT_CYCLES);
  logic [CNT_W+1:0] lock_q, lock_d;

  assign auto_en = (lock_q == '0);

  always_comb begin
    lock_d = lock_q;
    if (manual_grant) begin
      lock_d = LockLoad;
    end else if (lock_q != '0) begin
      lock_d = lock_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= '0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  assign auto_en = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    grant_d      = grant_q;
    manual_grant = 1'b0;
    case (state_q)
      StIdle: begin
        if (!stop) begin
          if (win_up && !lim_top) begin
            state_d      = StUp;
            grant_d      = man_any ? 2'b01 : 2'b10;
            manual_grant = man_any;
          end else if (win_dn && !lim_bot) begin
            state_d      = StDown;
            grant_d      = man_any ? 2'b01 : 2'b10;
            manual_grant = man_any;
          end
        end
      end
      StUp: begin
        if (lim_top || stop) begin
          state_d = StDead;
          pend_d  = PendNone;
        end else if (cnt_q == TravelLast) begin
          state_d = StFault;
        end else if (man_dn) begin
          state_d = StDead;
          pend_d  = PendDn;
        end
      end
      StDown: begin
        if (lim_bot || stop) begin
          state_d = StDead;
          pend_d  = PendNone;
        end else if (cnt_q == TravelLast) begin
          state_d = StFault;
        end else if (man_up) begin
          state_d = StDead;
          pend_d  = PendUp;
        end
      end
      StDead: begin
        if (stop) pend_d = PendNone;
        if (cnt_q == DeadLast) begin
          pend_d  = PendNone;
          state_d = StIdle;
          // Only manual reversals ever leave a pending direction.
          if (!stop && pend_q == PendUp && !lim_top) begin
            state_d      = StUp;
            grant_d      = 2'b01;
            manual_grant = 1'b1;
          end else if (!stop && pend_q == PendDn && !lim_bot) begin
            state_d      = StDown;
            grant_d      = 2'b01;
            manual_grant = 1'b1;
          end
        end
      end
      StFault: begin
        if (clear_fault) begin
          state_d = StDead;
          pend_d  = PendNone;
        end
      end
      default: state_d = StIdle;
    endcase

    // Both limits at once means a broken sensor; overrides everything else.
    if (lim_top && lim_bot && state_q != StFault) begin
      state_d      = StFault;
      pend_d       = PendNone;
      manual_grant = 1'b0;
    end
    if (state_d != StUp && state_d != StDown) grant_d = 2'b00;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == StUp || state_q == StDown) && cnt_q != TravelLast) begin
      cnt_d = cnt_q + 1'b1;
    end else if (state_q == StDead && cnt_q != DeadLast) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pend_q     <= PendNone;
      cnt_q      <= '0;
      grant_q    <= 2'b00;
      motor_up_q <= 1'b0;
      motor_dn_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      motor_up_q <= (state_d == StUp);
      motor_dn_q <= (state_d == StDown);
      fault_q    <= (state_d == StFault);
    end
  end

  assign motor_up  = motor_up_q;
  assign motor_dn  = motor_dn_q;
  assign grant_src = grant_q;
  assign state_o   = state_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_blind_motor_scheduler.sv
// Directed self-checking bench for blind_motor_scheduler (DEAD_CYCLES=4, TRAVEL_MAX=20).
module tb_blind_motor_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_man_up = 1'b0, req_man_dn = 1'b0, req_auto_up = 1'b0, req_auto_dn = 1'b0;
  logic       stop = 1'b0, clear_fault = 1'b0, lim_top = 1'b0, lim_bot = 1'b0;
  logic       motor_up, motor_dn, fault;
  logic [1:0] grant_src;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  blind_motor_scheduler #(
    .DEAD_CYCLES   (4),
    .TRAVEL_MAX    (20),
    .CNT_W         (12)
`ifdef AUTO_LOCKOUT_EN
    ,
    .LOCKOUT_CYCLES(10)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_man_up (req_man_up),
    .req_man_dn (req_man_dn),
    .req_auto_up(req_auto_up),
    .req_auto_dn(req_auto_dn),
    .stop       (stop),
    .clear_fault(clear_fault),
    .lim_top    (lim_top),
    .lim_bot    (lim_bot),
    .motor_up   (motor_up),
    .motor_dn   (motor_dn),
    .grant_src  (grant_src),
    .state_o    (state_o),
    .fault      (fault)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks every output against its expected value: up, dn, grant, state, fault.
  task automatic chk_all(input string tag, input logic up, input logic dn, input logic [1:0] gs,
                         input logic [2:0] st, input logic flt);
    chk({tag, ".motor_up"}, {15'd0, motor_up}, {15'd0, up});
    chk({tag, ".motor_dn"}, {15'd0, motor_dn}, {15'd0, dn});
    chk({tag, ".grant"}, {14'd0, grant_src}, {14'd0, gs});
    chk({tag, ".state"}, {13'd0, state_o}, {13'd0, st});
    chk({tag, ".fault"}, {15'd0, fault}, {15'd0, flt});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset
    #2 rst = 1'b1;
    #1 chk_all("reset", 1'b0, 1'b0, 2'b00, 3'd0, 1'b0);
    #9 rst = 1'b0;
    tick();
    chk_all("reset_idle", 1'b0, 1'b0, 2'b00, 3'd0, 1'b0);

    // Manual up, stopped by top limit, then dead time
    req_man_up = 1'b1;
    tick();
    chk_all("man_up", 1'b1, 1'b0, 2'b01, 3'd1, 1'b0);
    req_man_up = 1'b0;
    ticks(7);
    chk_all("man_up_hold", 1'b1, 1'b0, 2'b01, 3'd1, 1'b0);
    lim_top = 1'b1;
    tick();
    chk_all("lim_top_dead", 1'b0, 1'b0, 2'b00, 3'd3, 1'b0);
    ticks(3);
    chk_all("dead_3", 1'b0, 1'b0, 2'b00, 3'd3, 1'b0);
    tick();
    chk_all("dead_to_idle", 1'b0, 1'b0, 2'b00, 3'd0, 1'b0);
    // Up request toward the asserted top limit is ignored
    req_man_up = 1'b1;
    tick();
    chk_all("at_limit_ignored", 1'b0, 1'b0, 2'b00, 3'd0, 1'b0);
    req_man_up = 1'b0;
    lim_top = 1'b0;

    // Auto down, reversed by manual up
    req_auto_dn = 1'b1;
    tick();
    chk_all("auto_dn", 1'b0, 1'b1, 2'b10, 3'd2, 1'b0);
    req_auto_dn = 1'b0;
    tick();
    req_man_up = 1'b1;
    tick();
    chk_all("rev_dead0", 1'b0, 1'b0, 2'b00, 3'd3, 1'b0);
    req_man_up = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_all("rev_dead", 1'b0, 1'b0, 2'b00, 3'd3, 1'b0);
    end
    tick();
    chk_all("rev_up", 1'b1, 1'b0, 2'b01, 3'd1, 1'b0);
    stop = 1'b1;
    tick();
    chk_all("stop_dead", 1'b0, 1'b0, 2'b00, 3'd3, 1'b0);
    stop = 1'b0;
    ticks(4);
    chk_all("stop_idle", 1'b0, 1'b0, 2'b00, 3'd0, 1'b0);

    // Priority: manual down beats auto up; stop beats both
    req_man_dn  = 1'b1;
    req_auto_up = 1'b1;
    tick();
    chk_all("prio_man", 1'b0, 1'b1, 2'b01, 3'd2, 1'b0);
    req_man_dn  = 1'b0;
    req_auto_up = 1'b0;
    stop        = 1'b1;
    ticks(5);
    chk_all("prio_stop_idle", 1'b0, 1'b0, 2'b00, 3'd0, 1'b0);
    req_man_dn  = 1'b1;
    req_auto_up = 1'b1;
    tick();
    chk_all("prio_stop", 1'b0, 1'b0, 2'b00, 3'd0, 1'b0);
    req_man_dn  = 1'b0;
    req_auto_up = 1'b0;
    stop        = 1'b0;

    // Travel timeout
    req_auto_up = 1'b1;
    tick();
    chk_all("to_up", 1'b1, 1'b0, 2'b10, 3'd1, 1'b0);
    req_auto_up = 1'b0;
    ticks(19);
    chk_all("to_up_20", 1'b1, 1'b0, 2'b10, 3'd1, 1'b0);
    tick();
    chk_all("to_fault", 1'b0, 1'b0, 2'b00, 3'd4, 1'b1);
    req_man_up = 1'b1;
    ticks(2);
    chk_all("fault_ignores", 1'b0, 1'b0, 2'b00, 3'd4, 1'b1);
    clear_fault = 1'b1;
    tick();
    chk_all("clear_dead", 1'b0, 1'b0, 2'b00, 3'd3, 1'b0);
    clear_fault = 1'b0;
    req_man_up  = 1'b0;
    ticks(3);
    chk_all("clear_dead3", 1'b0, 1'b0, 2'b00, 3'd3, 1'b0);
    tick();
    chk_all("clear_idle", 1'b0, 1'b0, 2'b00, 3'd0, 1'b0);

    // Sensor error: both limits during UP
    req_man_up = 1'b1;
    tick();
    req_man_up = 1'b0;
    chk_all("sens_up", 1'b1, 1'b0, 2'b01, 3'd1, 1'b0);
    lim_top = 1'b1;
    lim_bot = 1'b1;
    tick();
    chk_all("sens_fault", 1'b0, 1'b0, 2'b00, 3'd4, 1'b1);
    lim_top     = 1'b0;
    lim_bot     = 1'b0;
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    ticks(4);
    chk_all("sens_idle", 1'b0, 1'b0, 2'b00, 3'd0, 1'b0);

    // Asynchronous reset mid-DOWN
    req_man_dn = 1'b1;
    tick();
    req_man_dn = 1'b0;
    chk_all("ar_down", 1'b0, 1'b1, 2'b01, 3'd2, 1'b0);
    #2 rst = 1'b1;
    #1 chk_all("ar_reset", 1'b0, 1'b0, 2'b00, 3'd0, 1'b0);
    #2 rst = 1'b0;
    tick();
    chk_all("ar_idle", 1'b0, 1'b0, 2'b00, 3'd0, 1'b0);

`ifdef AUTO_LOCKOUT_EN
    // Lockout: auto ignored until 10 cycles after the manual grant
    req_man_up = 1'b1;
    tick();
    req_man_up = 1'b0;
    chk_all("lk_up", 1'b1, 1'b0, 2'b01, 3'd1, 1'b0);
    lim_top = 1'b1;
    tick();
    lim_top = 1'b0;
    ticks(4);
    chk_all("lk_idle", 1'b0, 1'b0, 2'b00, 3'd0, 1'b0);
    req_auto_dn = 1'b1;
    ticks(5);
    chk_all("lk_blocked", 1'b0, 1'b0, 2'b00, 3'd0, 1'b0);
    tick();
    chk_all("lk_down", 1'b0, 1'b1, 2'b10, 3'd2, 1'b0);
    req_auto_dn = 1'b0;
`else
    // Without lockout, auto is accepted right after a manual move
    req_man_up = 1'b1;
    tick();
    req_man_up = 1'b0;
    lim_top = 1'b1;
    tick();
    lim_top = 1'b0;
    ticks(4);
    req_auto_dn = 1'b1;
    tick();
    chk_all("nolk_down", 1'b0, 1'b1, 2'b10, 3'd2, 1'b0);
    req_auto_dn = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
